// File: rtl/reg_file_8bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_8bit_pkg
//  Description : Shared sizing constants for the 8-bit register file and its
//                pending-load scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_8bit_pkg;

  // Data width of every register and data port
  localparam int WIDTH    = 8;
  // Register address width; register count is 2**AW
  localparam int AW       = 3;
  localparam int NREGS    = 2 ** AW;
  // Hard-wired zero register index
  localparam int ZERO_REG = 0;

endpackage : reg_file_8bit_pkg
`default_nettype wire

// File: rtl/reg_file_8bit_pend_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : pend_scoreboard
//  Description : One pending bit per register marking an outstanding load.
//                Set by pend_set_i, cleared by a write to the same register,
//                set wins on a same-edge collision. Produces per-port busy
//                flags that drop in the cycle the load result is forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module pend_scoreboard
  import reg_file_8bit_pkg::*;
#(
  parameter int AW = reg_file_8bit_pkg::AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pend_set_i,
  input  logic [AW-1:0] pend_addr_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic          busy1_o,
  output logic          busy2_o
);

  localparam int            c_nregs     = 2 ** AW;
  localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);

  logic [c_nregs-1:0] pend_q;
  logic [c_nregs-1:0] pend_d;
  logic               w_fwd1;
  logic               w_fwd2;

  // Next pending vector: clear on write, then set on pend_set so a new load wins
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < c_nregs; i++) begin
      if (we_i && (wa_i == AW'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (pend_set_i && (pend_addr_i == AW'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  // Pending vector register, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A write landing this cycle on the read address satisfies the operand
  assign w_fwd1 = we_i && (wa_i == ra1_i) && (wa_i != c_zero_addr);
  assign w_fwd2 = we_i && (wa_i == ra2_i) && (wa_i != c_zero_addr);

  // Pending state is being discarded while reset is high, so never report busy
  assign busy1_o = !rst_i && pend_q[ra1_i] && !w_fwd1;
  assign busy2_o = !rst_i && pend_q[ra2_i] && !w_fwd2;

endmodule : pend_scoreboard
`default_nettype wire

// File: rtl/reg_file_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_8bit
//  Description : 8 x 8-bit register file, two combinational read ports, one
//                write port with write-to-read forwarding, r0 hard-wired to
//                zero, and a pending-load scoreboard producing busy/stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_8bit #(
  parameter int WIDTH = reg_file_8bit_pkg::WIDTH,
  parameter int AW    = reg_file_8bit_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic             busy1,
  output logic             busy2,
  output logic             stall
);

  import reg_file_8bit_pkg::*;

  localparam int            c_nregs     = 2 ** AW;
  localparam logic [AW-1:0] c_zero_addr = AW'(ZERO_REG);

  // Storage for r1..r(N-1); r0 has no flops
  logic [WIDTH-1:0] regs_q [1:c_nregs-1];
  // Architectural view of all registers including the constant r0
  logic [WIDTH-1:0] w_regs [c_nregs];
  logic             w_fwd1;
  logic             w_fwd2;
  logic [WIDTH-1:0] w_rd1_store;
  logic [WIDTH-1:0] w_rd2_store;

  assign w_regs[ZERO_REG] = '0;

  generate
    for (genvar gi = 1; gi < c_nregs; gi++) begin : g_regs
      // Register gi: cleared by reset, loaded when addressed by the write port
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else if (we && (wa == AW'(gi))) begin
          regs_q[gi] <= wd;
        end
      end
      assign w_regs[gi] = regs_q[gi];
    end
  endgenerate

  // Forward the write data when it targets the address being read
  assign w_fwd1 = we && (wa == ra1) && (wa != c_zero_addr);
  assign w_fwd2 = we && (wa == ra2) && (wa != c_zero_addr);

  // Stored values read as zero while reset is high, since they are being discarded
  always_comb begin
    w_rd1_store = '0;
    w_rd2_store = '0;
    if (!reset) begin
      w_rd1_store = w_regs[ra1];
      w_rd2_store = w_regs[ra2];
    end
  end

  assign rd1 = w_fwd1 ? wd : w_rd1_store;
  assign rd2 = w_fwd2 ? wd : w_rd2_store;

  pend_scoreboard #(
    .AW (AW)
  ) u_pend_scoreboard (
    .clk_i       (clk),
    .rst_i       (reset),
    .pend_set_i  (pend_set),
    .pend_addr_i (pend_addr),
    .we_i        (we),
    .wa_i        (wa),
    .ra1_i       (ra1),
    .ra2_i       (ra2),
    .busy1_o     (busy1),
    .busy2_o     (busy2)
  );

  assign stall = busy1 | busy2;

endmodule : reg_file_8bit
`default_nettype wire

// File: tb/tb_reg_file_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_8bit
//  Description : Self-checking bench for reg_file_8bit. A reference model of
//                registers and pending bits produces expected outputs that
//                are queued when inputs are driven and compared at negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_8bit;

  logic       clk;
  logic       reset;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       pend_set;
  logic [2:0] pend_addr;
  logic       busy1;
  logic       busy2;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] mreg  [8];
  logic       mpend [8];

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  reg_file_8bit #(.WIDTH(8), .AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .busy1     (busy1),
    .busy2     (busy2),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] ra);
    if (we && wa != 3'd0 && wa == ra) return wd;
    if (reset || ra == 3'd0) return 8'h00;
    return mreg[ra];
  endfunction

  function automatic logic exp_busy(input logic [2:0] ra);
    if (reset || ra == 3'd0) return 1'b0;
    if (we && wa == ra) return 1'b0;
    return mpend[ra];
  endfunction

  // Queue expectations for the current inputs, then compare at negedge
  task automatic sample(input string tag);
    exp_t e;
    logic [7:0] obs;
    string nm;
    logic b1, b2;
    b1 = exp_busy(ra1);
    b2 = exp_busy(ra2);
    sb.push_back('{tag, 0, exp_rd(ra1)});
    sb.push_back('{tag, 1, exp_rd(ra2)});
    sb.push_back('{tag, 2, {7'd0, b1}});
    sb.push_back('{tag, 3, {7'd0, b2}});
    sb.push_back('{tag, 4, {7'd0, b1 | b2}});
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        0:       begin obs = rd1;            nm = "rd1";   end
        1:       begin obs = rd2;            nm = "rd2";   end
        2:       begin obs = {7'd0, busy1};  nm = "busy1"; end
        3:       begin obs = {7'd0, busy2};  nm = "busy2"; end
        default: begin obs = {7'd0, stall};  nm = "stall"; end
      endcase
      chk_eq({e.tag, "_", nm}, obs, e.val);
    end
  endtask

  // Advance one clock edge and update the model with the inputs in force
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mreg[i]  = 8'h00;
        mpend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 3'd0) mreg[wa] = wd;
      if (we) mpend[wa] = 1'b0;
      if (pend_set && pend_addr != 3'd0) mpend[pend_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; pend_set = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mreg[i]  = 8'h00;
      mpend[i] = 1'b0;
    end
    reset = 1'b1; we = 1'b0; wa = 3'd0; wd = 8'h00;
    pend_set = 1'b0; pend_addr = 3'd0; ra1 = 3'd0; ra2 = 3'd0;
    @(posedge clk); #1;
    sample("rst_during");
    tick();
    idle();

    // Read all addresses after reset
    for (int a = 0; a < 8; a++) begin
      ra1 = a[2:0];
      ra2 = 3'(7 - a);
      sample("rst_read");
      chk_eq("rst_rd1_zero", rd1, 8'h00);
      chk_eq("rst_stall_zero", {7'd0, stall}, 8'h00);
      tick();
    end

    // Write r3, read back on both ports
    we = 1'b1; wa = 3'd3; wd = 8'hA5;
    sample("wr_r3");
    tick();
    idle(); ra1 = 3'd3; ra2 = 3'd3;
    sample("rd_r3");
    chk_eq("r3_rd1", rd1, 8'hA5);
    chk_eq("r3_rd2", rd2, 8'hA5);

    // Write to r0 is ignored
    we = 1'b1; wa = 3'd0; wd = 8'h77; ra1 = 3'd0;
    sample("wr_r0");
    chk_eq("r0_no_fwd", rd1, 8'h00);
    tick();
    idle();
    sample("rd_r0");
    chk_eq("r0_rd1", rd1, 8'h00);

    // Same-cycle forwarding
    we = 1'b1; wa = 3'd5; wd = 8'h3C; ra1 = 3'd5;
    sample("fwd_r5");
    chk_eq("fwd_before", rd1, 8'h3C);
    tick();
    idle();
    sample("fwd_r5_after");
    chk_eq("fwd_after", rd1, 8'h3C);

    // Pending load on r2, resolved by a write
    pend_set = 1'b1; pend_addr = 3'd2;
    sample("pend_r2_set");
    tick();
    idle(); ra2 = 3'd2;
    sample("pend_r2_busy");
    chk_eq("busy2_set", {7'd0, busy2}, 8'h01);
    chk_eq("stall_set", {7'd0, stall}, 8'h01);
    we = 1'b1; wa = 3'd2; wd = 8'h11;
    sample("pend_r2_wr");
    chk_eq("busy2_fwd", {7'd0, busy2}, 8'h00);
    chk_eq("rd2_fwd", rd2, 8'h11);
    tick();
    idle();
    sample("pend_r2_clr");
    chk_eq("busy2_clr", {7'd0, busy2}, 8'h00);

    // Set and clear on the same edge: set wins
    pend_set = 1'b1; pend_addr = 3'd4; we = 1'b1; wa = 3'd4; wd = 8'h99;
    sample("setclr_r4");
    tick();
    idle(); ra1 = 3'd4;
    sample("setclr_r4_after");
    chk_eq("r4_val", rd1, 8'h99);
    chk_eq("r4_busy", {7'd0, busy1}, 8'h01);

    // Pend on r0 is ignored
    pend_set = 1'b1; pend_addr = 3'd0;
    sample("pend_r0");
    tick();
    idle(); ra1 = 3'd0;
    sample("pend_r0_after");
    chk_eq("r0_busy", {7'd0, busy1}, 8'h00);

    // Reset during an outstanding load
    pend_set = 1'b1; pend_addr = 3'd6;
    sample("pend_r6");
    tick();
    idle(); we = 1'b1; wa = 3'd1; wd = 8'hFF;
    sample("wr_r1");
    tick();
    idle(); reset = 1'b1; ra1 = 3'd1; ra2 = 3'd6;
    sample("rst_pulse");
    tick();
    idle();
    sample("post_rst");
    chk_eq("post_rst_r1", rd1, 8'h00);
    chk_eq("post_rst_busy6", {7'd0, busy2}, 8'h00);
    chk_eq("post_rst_stall", {7'd0, stall}, 8'h00);
    we = 1'b1; wa = 3'd6; wd = 8'h42;
    sample("wr_r6");
    tick();
    idle();
    sample("rd_r6");
    chk_eq("r6_val", rd2, 8'h42);

    // Random traffic checked against the model
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 19) == 0);
      we        = $urandom_range(0, 1);
      wa        = 3'($urandom_range(0, 7));
      wd        = 8'($urandom);
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = 3'($urandom_range(0, 7));
      ra1       = 3'($urandom_range(0, 7));
      ra2       = ($urandom_range(0, 3) == 0) ? ra1 : 3'($urandom_range(0, 7));
      sample("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file_8bit
`default_nettype wire

// File: doc/reg_file_8bit.md
REG_FILE_8BIT -- requirements
Module: reg_file_8bit

Interface
REQ-001 Parameter: WIDTH, 8, data width of every register and data port.
REQ-002 Parameter: AW, 3, register address width; register count = 2**AW (8).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ra1  input  AW  read address, port 1.
REQ-006 Port: ra2  input  AW  read address, port 2.
REQ-007 Port: rd1  output  WIDTH  read data, port 1; feeds 2:1 operand mux input a.
REQ-008 Port: rd2  output  WIDTH  read data, port 2; feeds 2:1 operand mux input a.
REQ-009 Port: we  input  1  write enable.
REQ-010 Port: wa  input  AW  write address.
REQ-011 Port: wd  input  WIDTH  write data.
REQ-012 Port: pend_set  input  1  marks register pend_addr as awaiting a load result.
REQ-013 Port: pend_addr  input  AW  register to mark pending.
REQ-014 Port: busy1  output  1  ra1 operand not yet valid.
REQ-015 Port: busy2  output  1  ra2 operand not yet valid.
REQ-016 Port: stall  output  1  busy1 OR busy2.

Function
REQ-017 Register r0 SHALL read 0 always; writes and pend_set to address 0 SHALL be ignored.
REQ-018 On a rising edge with we=1 and wa!=0, reg[wa] SHALL take wd; no other register changes.
REQ-019 rd1/rd2 SHALL be combinational from the current addresses, with zero cycles of latency.
REQ-020 Bypass: if we=1, wa!=0 and wa==raN, rdN SHALL equal wd in the same cycle (write-to-read forwarding).
REQ-021 Pending bit pend[i] SHALL set on a rising edge with pend_set=1 and pend_addr==i (i!=0).
REQ-022 pend[i] SHALL clear on a rising edge with we=1 and wa==i.
REQ-023 Set and clear of the same address on the same edge: set SHALL win (a new load supersedes the old one).
REQ-024 busyN SHALL equal pend[raN] AND NOT (we AND wa==raN AND wa!=0); combinational.
REQ-025 busyN SHALL be 0 whenever raN==0.
REQ-026 Both read ports on the same address SHALL return identical data and busy values.
REQ-027 Setting an already-pending register SHALL leave it pending, with no error.
REQ-028 Writing a non-pending register SHALL have no effect on any pend bit.

Reset
REQ-029 On a rising edge with reset=1, all registers and all pend bits SHALL become 0, overriding we and pend_set on that edge.
REQ-030 During and immediately after reset: rd1=rd2=0, busy1=busy2=stall=0, unless the same-cycle bypass of REQ-020 applies.
REQ-031 If reset is asserted during an outstanding load, the pending state SHALL be discarded, and a later write to that register SHALL behave as a normal write.

Structure
REQ-032 WIDTH, AW and the constant ZERO_REG=0 SHALL live in a shared package/include used by the datapath.
REQ-033 Pending tracking SHALL be a sub-module named pend_scoreboard (pend vector, set/clear logic, busy outputs); the storage array and bypass logic SHALL stay in reg_file_8bit.

Verification
REQ-034 The bench SHALL apply reset, then read all 8 addresses; required: every rdN=0 and stall=0.
REQ-035 The bench SHALL write 0xA5 to r3, then read r3 on both ports the next cycle; required: rd1=rd2=0xA5. It SHALL then write 0x77 to r0 and read r0; required: 0x00.
REQ-036 The bench SHALL apply we=1, wa=5, wd=0x3C with ra1=5 in the same cycle; required: rd1=0x3C before the edge, and still 0x3C after it.
REQ-037 The bench SHALL pend_set r2, then read ra2=2; required: busy2=1, stall=1. In the cycle where we=1, wa=2, wd=0x11 is applied, required: busy2=0 and rd2=0x11. After that edge, required: pend[2]=0.
REQ-038 The bench SHALL apply pend_set=1, pend_addr=4 together with we=1, wa=4, wd=0x99 on the same edge; required: r4=0x99 and busy for r4=1 afterwards.
REQ-039 The bench SHALL pend r6, write 0xFF to r1, then assert reset for one cycle; required: r1=0, pend[6]=0, stall=0.
